// File: rtl/adc128s_fc.sv
// rtl/adc128s_fc.sv - 8-channel 12-bit SPI A2D converter model (ADC128S protocol)
module adc128s_fc #(
  parameter logic [11:0] UNUSED_VAL = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] ld_cell_lft,
  input  logic [11:0] ld_cell_rght,
  input  logic [11:0] steerPot,
  input  logic [11:0] batt
);

  logic        ss1, ss2, ss3;
  logic        sclk1, sclk2, sclk3;
  logic        mosi1, mosi2;
  logic        ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic [15:0] rx_shft;
  logic [15:0] tx_shft;
  logic [4:0]  bit_cnt;
  logic [2:0]  chan;
  logic [11:0] sample;

  // Select and clock lines reset to their idle-high level so no false edge follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss1   <= 1'b1; ss2   <= 1'b1; ss3   <= 1'b1;
      sclk1 <= 1'b1; sclk2 <= 1'b1; sclk3 <= 1'b1;
      mosi1 <= 1'b0; mosi2 <= 1'b0;
    end else begin
      ss1   <= SS_n; ss2   <= ss1;   ss3   <= ss2;
      sclk1 <= SCLK; sclk2 <= sclk1; sclk3 <= sclk2;
      mosi1 <= MOSI; mosi2 <= mosi1;
    end
  end

  assign ss_fall   = ~ss2 & ss3;
  assign ss_rise   = ss2 & ~ss3;
  assign sclk_rise = sclk2 & ~sclk3;
  assign sclk_fall = ~sclk2 & sclk3;

  always_comb begin
    sample = UNUSED_VAL;
    case (chan)
      3'd0:    sample = ld_cell_lft;
      3'd4:    sample = ld_cell_rght;
      3'd5:    sample = steerPot;
      3'd6:    sample = batt;
      default: sample = UNUSED_VAL;
    endcase
  end

  // bit_cnt == 0 marks the leading fall from idle-high, which must not shift out the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_shft <= '0;
      tx_shft <= '0;
      bit_cnt <= '0;
      chan    <= '0;
    end else if (ss_fall) begin
      tx_shft <= {4'b0000, sample};
      bit_cnt <= '0;
    end else if (ss_rise) begin
      if (bit_cnt == 5'd16)
        chan <= rx_shft[13:11];
      bit_cnt <= '0;
    end else if (!ss2) begin
      if (sclk_rise) begin
        rx_shft <= {rx_shft[14:0], mosi2};
        if (bit_cnt != 5'd16)
          bit_cnt <= bit_cnt + 5'd1;
      end else if (sclk_fall && bit_cnt != 5'd0) begin
        tx_shft <= {tx_shft[14:0], 1'b0};
      end
    end
  end

  assign MISO = tx_shft[15];

endmodule

// File: tb/tb_adc128s_fc.sv
// tb/tb_adc128s_fc.sv - directed-vector bench for adc128s_fc
module tb_adc128s_fc;

  localparam int HP = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic [11:0] ld_cell_lft  = 12'd700;
  logic [11:0] ld_cell_rght = 12'd450;
  logic [11:0] steerPot     = 12'h123;
  logic [11:0] batt         = 12'hFFF;

  int          vectors = 0;
  int          errors  = 0;
  logic [15:0] resp;

  adc128s_fc dut (
    .clk          (clk),
    .rst          (rst),
    .SS_n         (SS_n),
    .SCLK         (SCLK),
    .MOSI         (MOSI),
    .MISO         (MISO),
    .ld_cell_lft  (ld_cell_lft),
    .ld_cell_rght (ld_cell_rght),
    .steerPot     (steerPot),
    .batt         (batt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Shifts cmd[n-1:0] MSB first; resp holds MISO as seen at the first 16 rises.
  task automatic spi_frame(input logic [19:0] cmd, input int n, output logic [15:0] r);
    r = '0;
    SS_n = 1'b0;
    tick(HP);
    for (int i = n - 1; i >= 0; i--) begin
      SCLK = 1'b0;
      MOSI = cmd[i];
      tick(HP);
      if (i >= n - 16) r = {r[14:0], MISO};
      SCLK = 1'b1;
      tick(HP);
    end
    SS_n = 1'b1;
    MOSI = 1'b0;
    tick(HP);
  endtask

  initial begin
    tick(4);
    rst = 1'b0;
    tick(4);
    chk("reset_miso", {15'd0, MISO}, 16'h0000);

    spi_frame(20'h02000, 16, resp); chk("post_reset_ch0", resp, 16'h02BC);
    spi_frame(20'h00000, 16, resp); chk("sel_ch4", resp, 16'h01C2);
    spi_frame(20'h03000, 16, resp); chk("sel_ch0", resp, 16'h02BC);
    spi_frame(20'h02800, 16, resp); chk("sel_ch6_batt", resp, 16'h0FFF);

    spi_frame(20'h03000, 16, resp); chk("pipe_steer", resp, 16'h0123);
    spi_frame(20'h00000, 16, resp); chk("pipe_batt", resp, 16'h0FFF);
    spi_frame(20'h01800, 16, resp); chk("pipe_ch0", resp, 16'h02BC);

    spi_frame(20'h03800, 16, resp); chk("unmapped_ch3", resp, 16'h0000);
    spi_frame(20'h02800, 16, resp); chk("unmapped_ch7", resp, 16'h0000);

    spi_frame(20'h00020, 8, resp);
    spi_frame(20'h00000, 16, resp); chk("abort_keeps_ch5", resp, 16'h0123);
    spi_frame(20'h02800, 16, resp); chk("after_abort_ch0", resp, 16'h02BC);

    fork
      spi_frame(20'h00000, 16, resp);
      begin tick(5 * HP); steerPot = 12'h456; end
    join
    chk("sample_at_ss_fall", resp, 16'h0123);
    spi_frame(20'h02800, 16, resp); chk("ch0_again", resp, 16'h02BC);
    spi_frame(20'h00000, 16, resp); chk("new_steer", resp, 16'h0456);

    spi_frame(20'hF3000, 20, resp); chk("long_frame_resp", resp, 16'h02BC);
    spi_frame(20'h03000, 16, resp); chk("long_frame_chan6", resp, 16'h0FFF);

    SS_n = 1'b0;
    tick(HP);
    for (int i = 0; i < 5; i++) begin
      SCLK = 1'b0; tick(HP);
      SCLK = 1'b1; tick(HP);
    end
    chk("mid_frame_bit11", {15'd0, MISO}, 16'h0001);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_frame_miso", {15'd0, MISO}, 16'h0000);
    @(negedge clk);
    SS_n = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(4);
    spi_frame(20'h00000, 16, resp); chk("rst_chan0", resp, 16'h02BC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/adc128s_fc.md
# adc128s_fc

Behavioural-but-synthesizable model of an 8-channel, 12-bit SPI A2D converter, with the same channel map and protocol as the ADC128S part. It sits in the Segway system-level bench between the DUT's A2D SPI master and the bench stimulus. The stimulus consists of the load-cell, steering-potentiometer and battery values. Each 16-bit SPI frame selects the channel for the next frame and returns the 12-bit result of the channel selected by the previous frame.

## Interface
- Parameters:
- UNUSED_VAL, default 12'h000: value returned for unmapped channels 1, 2, 3 and 7.
- Ports. One clock; reset is synchronous and active-high.
- clk, in, 1: system clock. All state changes on its rising edge.
- rst, in, 1: synchronous active-high reset.
- SS_n, in, 1: SPI slave select, active low.
- SCLK, in, 1: SPI clock. Idles high; MOSI is sampled on the rise and MISO changes on the fall.
- MOSI, in, 1: command data, MSB first.
- MISO, out, 1: result data, MSB first.
- ld_cell_lft, in, 12: value for channel 0.
- ld_cell_rght, in, 12: value for channel 4.
- steerPot, in, 12: value for channel 5.
- batt, in, 12: value for channel 6.

## Operation
- Input conditioning:
  - SS_n, SCLK and MOSI each pass through a 2-flop synchronizer.
  - A third flop on SCLK and on SS_n gives edge detection.
  - sclk_rise = s2 & ~s3; sclk_fall = ~s2 & s3; ss_fall and ss_rise are defined the same way.
- Registers:
  - rx_shft[15:0]
  - tx_shft[15:0]
  - bit_cnt[4:0]
  - chan[2:0]
  - MISO = tx_shft[15] at all times.
- On ss_fall:
  - tx_shft <= {4'b0000, sample}, where sample is the current input of channel chan (unmapped channel gives UNUSED_VAL).
  - bit_cnt <= 0.
  - rx_shft is unchanged.
- While SS_n (synchronized) is low:
  - On sclk_rise: rx_shft <= {rx_shft[14:0], MOSI_sync}; bit_cnt++, saturating at 16.
  - On sclk_fall with bit_cnt != 0: tx_shft <= {tx_shft[14:0], 1'b0}. A fall before the first rise, i.e. the leading fall from idle-high, does not shift.
- On ss_rise:
  - If bit_cnt == 16, then chan <= rx_shft[13:11] (command format {2'b00, ch[2:0], 11'bx}).
  - Otherwise the frame is aborted and chan is unchanged.
  - bit_cnt <= 0 in both cases.
- Precedence: edges are ignored while SS_n is high. The SS edge takes priority if it coincides with an SCLK edge.
- Typical master use is two frames:
  - Frame 1 sends the channel; its returned data is ignored.
  - Frame 2 returns the 12-bit value in MISO bits [11:0]. Bits [15:12] are 0.

## Timing
- Reset values:
  - All synchronizer flops: SS_n and SCLK chains = 1, MOSI chain = 0.
  - tx_shft = 0, so MISO = 0.
  - rx_shft = 0, bit_cnt = 0, chan = 0.
- Reset mid-frame aborts the frame immediately. The bench sees MISO = 0 on the clk edge after rst is sampled high.
- Latency: a pin transition set up before clk edge k is acted on at edge k+2, so register/MISO updates appear after edge k+2.
- The SCLK half-period must be ≥ 4 clk. The DUT master uses clk/32, which satisfies this.
- The channel sample is taken at ss_fall. Input changes after that do not affect the frame in progress.
- Frames longer than 16 rises: rx keeps shifting and tx shifts zeros. The frame still counts as complete; chan comes from the last 16 bits received.

## Test plan
- Reset: assert rst mid-frame → MISO = 0, chan = 0. The next frame returns ld_cell_lft (e.g. 12'h2BC → MISO word 16'h02BC).
- Channel select:
  - Set ld_cell_lft = 700 and ld_cell_rght = 450.
  - Frame 1 sends 16'h2000 (ch4), frame 2 sends any command → frame 2 returns 16'h01C2.
  - Then sending 16'h3000 (ch6) with batt = 12'hFFF → the next frame returns 16'h0FFF.
- Pipeline: commands ch5, ch6, ch0 sent back to back → responses are prev-chan, steerPot, batt in order. The upper 4 bits are always 0.
- Abort: SS_n raised after 8 SCLK rises while sending ch4 → chan unchanged, so the next frame returns the old channel's value.
- Unmapped channel: command ch3 (16'h1800) → the next frame returns 16'h0000 (UNUSED_VAL).
- Sample timing:
  - Change steerPot from 12'h123 to 12'h456 mid-frame → the current frame returns 12'h123.
  - Leading SCLK fall from idle-high before the first rise → MSB not lost.
